// File: rtl/arith_unit_arbiter_pkg.sv
// Shared types and constants for the two-requester arithmetic-unit arbiter.
package arith_arb_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_e;

    typedef struct packed {
        logic s1;
        logic s0;
        logic cin;
    } op_sel_t;

endpackage

// File: rtl/arith_unit_arbiter_if.sv
// Request, arithmetic-unit and response signals of the arbiter.
// master = requester/AU side, slave = arbiter side.
interface arith_unit_arbiter_if import arith_arb_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             req0_valid, req0_ready, req0_s1, req0_s0, req0_cin;
    logic [WIDTH-1:0] req0_a, req0_b;
    logic             req1_valid, req1_ready, req1_s1, req1_s0, req1_cin;
    logic [WIDTH-1:0] req1_a, req1_b;
    logic [WIDTH-1:0] au_a, au_b, au_g;
    logic             au_s0, au_s1, au_cin, au_cout;
    logic             rsp0_valid, rsp0_ready, rsp0_cout;
    logic [WIDTH-1:0] rsp0_g;
    logic             rsp1_valid, rsp1_ready, rsp1_cout;
    logic [WIDTH-1:0] rsp1_g;

    modport master (
        output req0_valid, req0_a, req0_b, req0_s1, req0_s0, req0_cin,
        output req1_valid, req1_a, req1_b, req1_s1, req1_s0, req1_cin,
        input  req0_ready, req1_ready,
        input  au_a, au_b, au_s0, au_s1, au_cin,
        output au_g, au_cout,
        input  rsp0_valid, rsp0_g, rsp0_cout, rsp1_valid, rsp1_g, rsp1_cout,
        output rsp0_ready, rsp1_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_s1, req0_s0, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_s1, req1_s0, req1_cin,
        output req0_ready, req1_ready,
        output au_a, au_b, au_s0, au_s1, au_cin,
        input  au_g, au_cout,
        output rsp0_valid, rsp0_g, rsp0_cout, rsp1_valid, rsp1_g, rsp1_cout,
        input  rsp0_ready, rsp1_ready
    );
endinterface

// File: rtl/arith_unit_arbiter_rr.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves
// past the winner only when the grant is actually taken.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic ptr_q, ptr_d;  // 1: requester 1 wins a tie

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign ptr_d = accept ? grant[0] : ptr_q;

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/arith_unit_arbiter.sv
// Shares one combinational arithmetic unit between two requesters.
// Optional busy-cycle counter output enabled by ARITH_ARB_BUSY_CNT_EN.
module arith_unit_arbiter import arith_arb_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    arith_unit_arbiter_if.slave  bus
`ifdef ARITH_ARB_BUSY_CNT_EN
    ,
    output logic [15:0]          busy_cnt
`endif
);
    state_e           state_q, state_d;
    logic [1:0]       req, grant;
    logic             accept, rsp_take;
    logic             idx_q;
    logic [WIDTH-1:0] a_q, b_q;
    op_sel_t          sel_q;
    logic [WIDTH-1:0] g0_q, g1_q;
    logic             c0_q, c1_q;

    assign req      = {bus.req1_valid, bus.req0_valid};
    assign accept   = (state_q == IDLE) && !rst && (grant != 2'b00);
    assign rsp_take = idx_q ? bus.rsp1_ready : bus.rsp0_ready;

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (rsp_take) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ready is masked during reset so nothing handshakes while rst is high
    always_comb begin
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.au_a       = '0;
        bus.au_b       = '0;
        bus.au_s1      = 1'b0;
        bus.au_s0      = 1'b0;
        bus.au_cin     = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req0_ready = grant[0] & ~rst;
                bus.req1_ready = grant[1] & ~rst;
            end
            ISSUE: begin
                bus.au_a   = a_q;
                bus.au_b   = b_q;
                bus.au_s1  = sel_q.s1;
                bus.au_s0  = sel_q.s0;
                bus.au_cin = sel_q.cin;
            end
            RESP: begin
                bus.rsp0_valid = ~idx_q;
                bus.rsp1_valid = idx_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sel_q <= '0;
            g0_q  <= '0;
            c0_q  <= 1'b0;
            g1_q  <= '0;
            c1_q  <= 1'b0;
        end else begin
            if (accept) begin
                idx_q <= grant[1];
                a_q   <= grant[1] ? bus.req1_a : bus.req0_a;
                b_q   <= grant[1] ? bus.req1_b : bus.req0_b;
                sel_q <= grant[1] ? op_sel_t'{bus.req1_s1, bus.req1_s0, bus.req1_cin}
                                  : op_sel_t'{bus.req0_s1, bus.req0_s0, bus.req0_cin};
            end
            if (state_q == ISSUE) begin
                if (idx_q) begin
                    g1_q <= bus.au_g;
                    c1_q <= bus.au_cout;
                end else begin
                    g0_q <= bus.au_g;
                    c0_q <= bus.au_cout;
                end
            end
        end
    end

    assign bus.rsp0_g    = g0_q;
    assign bus.rsp0_cout = c0_q;
    assign bus.rsp1_g    = g1_q;
    assign bus.rsp1_cout = c1_q;

`ifdef ARITH_ARB_BUSY_CNT_EN
    logic [15:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (state_q != IDLE && busy_q != 16'hFFFF) busy_d = busy_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy_cnt = busy_q;
`endif
endmodule

// File: tb/tb_arith_unit_arbiter.sv
// Self-checking bench: behavioural AU + round-robin/latency reference model.
module tb_arith_unit_arbiter;
    import arith_arb_pkg::*;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vec  = 0;
    int   miss = 0;
    int   last = 1;  // last granted requester; 1 so that requester 0 wins first
    logic [W-1:0] ra [2];
    logic [W-1:0] rb [2];
    logic [2:0]   rs [2];  // {s1, s0, cin}

    arith_unit_arbiter_if #(.WIDTH(W)) bus ();
`ifdef ARITH_ARB_BUSY_CNT_EN
    logic [15:0] busy_cnt;
`endif

    arith_unit_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef ARITH_ARB_BUSY_CNT_EN
        , .busy_cnt (busy_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W:0] au_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic s1, input logic s0, input logic cin);
        logic [W-1:0] y;
        case ({s1, s0})
            2'b00:   y = '0;
            2'b01:   y = b;
            2'b10:   y = ~b;
            default: y = '1;
        endcase
        return {1'b0, a} + {1'b0, y} + {{W{1'b0}}, cin};
    endfunction

    assign {bus.au_cout, bus.au_g} = au_model(bus.au_a, bus.au_b, bus.au_s1, bus.au_s0, bus.au_cin);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int idx, input logic v);
        if (idx == 0) begin
            bus.req0_valid = v; bus.req0_a = ra[0]; bus.req0_b = rb[0];
            {bus.req0_s1, bus.req0_s0, bus.req0_cin} = rs[0];
        end else begin
            bus.req1_valid = v; bus.req1_a = ra[1]; bus.req1_b = rb[1];
            {bus.req1_s1, bus.req1_s0, bus.req1_cin} = rs[1];
        end
    endtask

    task automatic randomize_req(input int idx);
        ra[idx] = $urandom;
        rb[idx] = $urandom;
        rs[idx] = 3'($urandom_range(0, 7));
    endtask

    function automatic logic [W:0] expect_rsp(input int idx);
        return au_model(ra[idx], rb[idx], rs[idx][2], rs[idx][1], rs[idx][0]);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        vec++;
        if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid} !== 4'b0) begin
            miss++; $display("FAIL reset_ctrl: got %b want 0000",
                             {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid});
        end
        vec++;
        if ({bus.au_a, bus.au_b, bus.au_s1, bus.au_s0, bus.au_cin} !== '0) begin
            miss++; $display("FAIL reset_au: au_a=%h au_b=%h want 0", bus.au_a, bus.au_b);
        end
        vec++;
        if ({bus.rsp0_g, bus.rsp0_cout, bus.rsp1_g, bus.rsp1_cout} !== '0) begin
            miss++; $display("FAIL reset_rsp: g0=%h g1=%h want 0", bus.rsp0_g, bus.rsp1_g);
        end
`ifdef ARITH_ARB_BUSY_CNT_EN
        vec++;
        if (busy_cnt !== 16'd0) begin
            miss++; $display("FAIL reset_busy: got %0d want 0", busy_cnt);
        end
`endif
        rst = 1'b0;
        last = 1;
    endtask

    task automatic test_single_add();
        ra[0] = 32'd5; rb[0] = 32'd3; rs[0] = 3'b010;
        drive(0, 1'b1);
        #1;
        vec++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
            miss++; $display("FAIL add_ready: got %b want 01", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        last = 0;
        drive(0, 1'b0);
        vec++;
        if (bus.au_a !== 32'd5 || bus.au_b !== 32'd3 || {bus.au_s1, bus.au_s0, bus.au_cin} !== 3'b010) begin
            miss++; $display("FAIL add_au: a=%h b=%h s=%b want 5 3 010", bus.au_a, bus.au_b,
                             {bus.au_s1, bus.au_s0, bus.au_cin});
        end
        vec++;
        if (bus.rsp0_valid !== 1'b0) begin
            miss++; $display("FAIL add_early_rsp: got %b want 0", bus.rsp0_valid);
        end
        tick();
        vec++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_g !== 32'd8 ||
            bus.rsp0_cout !== 1'b0 || bus.au_a !== '0) begin
            miss++; $display("FAIL add_rsp: v0=%b v1=%b g=%h c=%b au_a=%h want 1 0 8 0 0",
                             bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_g, bus.rsp0_cout, bus.au_a);
        end
        bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        vec++;
        if (bus.rsp0_valid !== 1'b0) begin
            miss++; $display("FAIL add_rsp_drop: got %b want 0", bus.rsp0_valid);
        end
    endtask

    task automatic test_sub_carry();
        ra[1] = 32'h10; rb[1] = 32'h1; rs[1] = 3'b101;
        drive(1, 1'b1);
        #1;
        vec++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
            miss++; $display("FAIL sub_ready: got %b want 10", {bus.req1_ready, bus.req0_ready});
        end
        tick();
        last = 1;
        drive(1, 1'b0);
        tick();
        vec++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 ||
            bus.rsp1_g !== 32'h0000000F || bus.rsp1_cout !== 1'b1) begin
            miss++; $display("FAIL sub_rsp: v1=%b v0=%b g=%h c=%b want 1 0 0000000f 1",
                             bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_g, bus.rsp1_cout);
        end
        bus.rsp1_ready = 1'b1;
        tick();
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_contention();
        logic [W:0] exp;
        int w;
        rst = 1'b1; tick(); rst = 1'b0; last = 1;
        for (int i = 0; i < 4; i++) begin
            randomize_req(0); randomize_req(1);
            drive(0, 1'b1); drive(1, 1'b1);
            #1;
            w = 1 - last;
            vec++;
            if ({bus.req1_ready, bus.req0_ready} !== 2'(1 << w) || w != (i % 2)) begin
                miss++; $display("FAIL cont_grant%0d: got %b want %b", i,
                                 {bus.req1_ready, bus.req0_ready}, 2'(1 << (i % 2)));
            end
            exp = expect_rsp(w);
            last = w;
            tick(); tick();
            bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
            #1;
            vec++;
            if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'(1 << w) ||
                (w == 0 ? {bus.rsp0_cout, bus.rsp0_g} : {bus.rsp1_cout, bus.rsp1_g}) !== exp) begin
                miss++; $display("FAIL cont_rsp%0d: valid=%b g0=%h g1=%h want valid=%b res=%h", i,
                                 {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp0_g, bus.rsp1_g, 2'(1 << w), exp);
            end
            tick();
            bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        end
        drive(0, 1'b0); drive(1, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [W:0] exp0, exp1;
        randomize_req(0); randomize_req(1);
        drive(0, 1'b1); drive(1, 1'b1);
        #1;
        vec++;
        if ({bus.req1_ready, bus.req0_ready} !== 2'(1 << (1 - last))) begin
            miss++; $display("FAIL bp_grant: got %b want %b", {bus.req1_ready, bus.req0_ready},
                             2'(1 << (1 - last)));
        end
        last = 0;
        exp0 = expect_rsp(0); exp1 = expect_rsp(1);
        tick();
        drive(0, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            vec++;
            if (bus.rsp0_valid !== 1'b1 || {bus.rsp0_cout, bus.rsp0_g} !== exp0 || bus.req1_ready !== 1'b0) begin
                miss++; $display("FAIL bp_hold%0d: v=%b res=%h r1=%b want 1 %h 0", c,
                                 bus.rsp0_valid, {bus.rsp0_cout, bus.rsp0_g}, bus.req1_ready, exp0);
            end
            tick();
        end
        bus.rsp0_ready = 1'b1;
        #1;
        vec++;
        if (bus.req1_ready !== 1'b0) begin
            miss++; $display("FAIL bp_early_accept: got %b want 0", bus.req1_ready);
        end
        tick();
        bus.rsp0_ready = 1'b0;
        vec++;
        if (bus.req1_ready !== 1'b1 || bus.rsp0_valid !== 1'b0) begin
            miss++; $display("FAIL bp_next_accept: r1=%b v0=%b want 1 0", bus.req1_ready, bus.rsp0_valid);
        end
        last = 1;
        tick();
        drive(1, 1'b0);
        tick();
        vec++;
        if (bus.rsp1_valid !== 1'b1 || {bus.rsp1_cout, bus.rsp1_g} !== exp1) begin
            miss++; $display("FAIL bp_rsp1: v=%b res=%h want 1 %h", bus.rsp1_valid,
                             {bus.rsp1_cout, bus.rsp1_g}, exp1);
        end
        bus.rsp1_ready = 1'b1;
        tick();
        bus.rsp1_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [W:0] exp;
        randomize_req(0);
        exp = expect_rsp(0);
        drive(0, 1'b1);
        bus.rsp0_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            vec++;
            if (bus.req0_ready !== (c % 3 == 0) || bus.rsp0_valid !== (c % 3 == 2) ||
                (c % 3 == 2 && {bus.rsp0_cout, bus.rsp0_g} !== exp)) begin
                miss++; $display("FAIL b2b_c%0d: ready=%b valid=%b res=%h want %b %b %h", c,
                                 bus.req0_ready, bus.rsp0_valid, {bus.rsp0_cout, bus.rsp0_g},
                                 c % 3 == 0, c % 3 == 2, exp);
            end
            tick();
        end
        drive(0, 1'b0);
        bus.rsp0_ready = 1'b0;
        last = 0;
    endtask

    task automatic test_random();
        logic [1:0] v;
        logic [W:0] exp;
        int w, dly;
        for (int i = 0; i < 40; i++) begin
            v = 2'($urandom_range(0, 3));
            randomize_req(0); randomize_req(1);
            drive(0, v[0]); drive(1, v[1]);
            #1;
            w = (v == 2'b11) ? 1 - last : (v[0] ? 0 : 1);
            vec++;
            if ({bus.req1_ready, bus.req0_ready} !== ((v == 2'b00) ? 2'b00 : 2'(1 << w))) begin
                miss++; $display("FAIL rnd_grant%0d: got %b req=%b last=%0d", i,
                                 {bus.req1_ready, bus.req0_ready}, v, last);
            end
            if (v == 2'b00) begin
                tick();
                continue;
            end
            exp = expect_rsp(w);
            last = w;
            tick();
            drive(0, 1'b0); drive(1, 1'b0);
            vec++;
            if (bus.au_a !== ra[w] || bus.au_b !== rb[w] || {bus.au_s1, bus.au_s0, bus.au_cin} !== rs[w]) begin
                miss++; $display("FAIL rnd_au%0d: a=%h b=%h want %h %h", i, bus.au_a, bus.au_b, ra[w], rb[w]);
            end
            tick();
            dly = $urandom_range(0, 3);
            for (int d = 0; d <= dly; d++) begin
                // the other requester may wiggle valid/ready: must be ignored
                if (w == 0) begin
                    bus.rsp0_ready = (d == dly); bus.rsp1_ready = 1'($urandom_range(0, 1));
                    bus.req1_valid = 1'($urandom_range(0, 1));
                end else begin
                    bus.rsp1_ready = (d == dly); bus.rsp0_ready = 1'($urandom_range(0, 1));
                    bus.req0_valid = 1'($urandom_range(0, 1));
                end
                #1;
                vec++;
                if ({bus.rsp1_valid, bus.rsp0_valid} !== 2'(1 << w) ||
                    (w == 0 ? {bus.rsp0_cout, bus.rsp0_g} : {bus.rsp1_cout, bus.rsp1_g}) !== exp ||
                    {bus.req1_ready, bus.req0_ready} !== 2'b00) begin
                    miss++; $display("FAIL rnd_rsp%0d_%0d: valid=%b g0=%h g1=%h want valid=%b res=%h",
                                     i, d, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp0_g, bus.rsp1_g,
                                     2'(1 << w), exp);
                end
                tick();
            end
            bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        end
        drive(0, 1'b0); drive(1, 1'b0);
    endtask

    task automatic test_reset_midop();
        logic [W:0] exp;
        randomize_req(0);
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        rst = 1'b1;
        tick();
        last = 1;
        vec++;
        if ({bus.au_a, bus.au_b, bus.au_s1, bus.au_s0, bus.au_cin, bus.req0_ready, bus.req1_ready,
             bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_g, bus.rsp0_cout, bus.rsp1_g, bus.rsp1_cout} !== '0) begin
            miss++; $display("FAIL midop_zero: au_a=%h v=%b g0=%h g1=%h want all 0",
                             bus.au_a, {bus.rsp1_valid, bus.rsp0_valid}, bus.rsp0_g, bus.rsp1_g);
        end
        rst = 1'b0;
        randomize_req(0);
        exp = expect_rsp(0);
        drive(0, 1'b1);
        #1;
        vec++;
        if (bus.req0_ready !== 1'b1) begin
            miss++; $display("FAIL midop_accept: got %b want 1", bus.req0_ready);
        end
        last = 0;
        tick();
        drive(0, 1'b0);
        vec++;
        if (bus.rsp0_valid !== 1'b0 || bus.au_a !== ra[0]) begin
            miss++; $display("FAIL midop_issue: v=%b au_a=%h want 0 %h", bus.rsp0_valid, bus.au_a, ra[0]);
        end
        tick();
        vec++;
        if (bus.rsp0_valid !== 1'b1 || {bus.rsp0_cout, bus.rsp0_g} !== exp) begin
            miss++; $display("FAIL midop_rsp: v=%b res=%h want 1 %h", bus.rsp0_valid,
                             {bus.rsp0_cout, bus.rsp0_g}, exp);
        end
        bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
    endtask

`ifdef ARITH_ARB_BUSY_CNT_EN
    task automatic test_busy_cnt();
        rst = 1'b1; tick(); rst = 1'b0; last = 1;
        randomize_req(0);
        drive(0, 1'b1);
        bus.rsp0_ready = 1'b1;
        repeat (9) tick();
        drive(0, 1'b0);
        vec++;
        if (busy_cnt !== 16'd6) begin
            miss++; $display("FAIL busy_three_ops: got %0d want 6", busy_cnt);
        end
        bus.rsp0_ready = 1'b0;
        drive(0, 1'b1);
        tick();
        drive(0, 1'b0);
        repeat (65540) tick();
        vec++;
        if (busy_cnt !== 16'hFFFF) begin
            miss++; $display("FAIL busy_sat: got %h want ffff", busy_cnt);
        end
        bus.rsp0_ready = 1'b1;
        tick();
        bus.rsp0_ready = 1'b0;
        last = 0;
    endtask
`endif

    initial begin
        ra[0] = '0; ra[1] = '0; rb[0] = '0; rb[1] = '0; rs[0] = '0; rs[1] = '0;
        drive(0, 1'b0); drive(1, 1'b0);
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        test_reset();
        test_single_add();
        test_sub_carry();
        test_contention();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_midop();
`ifdef ARITH_ARB_BUSY_CNT_EN
        test_busy_cnt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
